bcd_to_binary: RTL and testbench

//  Iterative packed-BCD to unsigned-binary converter (reverse double-dabble).
//  - Inverse of the on-board binary->BCD display path. Turns keyed/latched decimal

---
 rtl/bcd_pkg.sv | 19 +
 rtl/bcd_sub3_digit.sv | 14 +
 rtl/bcd_to_binary.sv | 117 +++++++++++
 tb/tb_bcd_to_binary.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the packed-BCD to binary converter.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        SUB3,
        DONE
    } b2b_state_t;

    localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

    function automatic logic digit_illegal(input bcd_digit_t d);
        return d > BCD_MAX_DIGIT;
    endfunction

endpackage

// File: rtl/bcd_sub3_digit.sv
// Reverse double-dabble digit correction: subtract 3 from digits of 8 or more.
// Latency: combinational.
// Backpressure: none, pure function of its input.
module bcd_sub3_digit
    import bcd_pkg::*;
(
    input  bcd_digit_t d_in,
    output bcd_digit_t d_out
);

    // A digit of 8+ after a right shift came from an odd upper digit; never underflows
    assign d_out = (d_in >= 4'd8) ? (d_in - 4'd3) : d_in;

endmodule

// File: rtl/bcd_to_binary.sv
// Iterative packed-BCD to unsigned-binary converter (reverse double-dabble), flags nibbles > 9.
// Latency: out_valid pulses 2*BIN_W cycles after the accept edge; one result per 2*BIN_W+1 cycles.
// Backpressure: in_ready low while converting; in_valid while busy is ignored, nothing is queued.
module bcd_to_binary
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int BIN_W      = 4 * NUM_DIGITS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    output logic                    out_valid,
    output logic [BIN_W-1:0]        bin_out,
    output logic                    out_error
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    b2b_state_t state_q;
    b2b_state_t state_d;

    logic [CNT_W-1:0] count_q;
    logic [BCD_W-1:0] bcd_q;
    logic [BIN_W-1:0] bin_q;
    logic             err_q;

    logic [BCD_W+BIN_W-1:0] work_sh;
    logic [BCD_W-1:0]       bcd_adj;
    logic                   in_err;
    logic                   accept;
    logic                   last_shift;

    assign in_ready   = (state_q == IDLE);
    assign accept     = in_valid && in_ready;
    assign last_shift = (state_q == SHIFT) && (count_q == LAST_CNT);
    assign work_sh    = {bcd_q, bin_q} >> 1;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_sub3
        bcd_sub3_digit u_sub3 (
            .d_in  (bcd_q[4*i +: 4]),
            .d_out (bcd_adj[4*i +: 4])
        );
    end

    always_comb begin
        in_err = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            in_err = in_err | digit_illegal(bcd_in[4*i +: 4]);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = SHIFT;
            SHIFT:   state_d = (count_q == LAST_CNT) ? DONE : SUB3;
            SUB3:    state_d = SHIFT;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            bcd_q   <= '0;
            bin_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        bcd_q   <= bcd_in;
                        bin_q   <= '0;
                        err_q   <= in_err;
                        count_q <= '0;
                    end
                end
                SHIFT: begin
                    {bcd_q, bin_q} <= work_sh;
                    count_q        <= count_q + CNT_W'(1);
                end
                SUB3:    bcd_q <= bcd_adj;
                default: ;
            endcase
        end
    end

    // Outputs are loaded on the edge into DONE so the pulse and data land in the DONE cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            bin_out   <= '0;
            out_error <= 1'b0;
        end else begin
            out_valid <= last_shift;
            if (last_shift) begin
                bin_out   <= err_q ? '0 : work_sh[BIN_W-1:0];
                out_error <= err_q;
            end
        end
    end

endmodule

// File: tb/tb_bcd_to_binary.sv
// Directed and randomised checks of bcd_to_binary at NUM_DIGITS=4.
module tb_bcd_to_binary;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] bcd_in = 16'h0000;
    logic        out_valid;
    logic [15:0] bin_out;
    logic        out_error;

    int total = 0;
    int fails = 0;

    bcd_to_binary #(.NUM_DIGITS(4), .BIN_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd_in    (bcd_in),
        .out_valid (out_valid),
        .bin_out   (bin_out),
        .out_error (out_error)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] bcd2bin(input logic [15:0] b);
        int v;
        v = int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
        return 16'(v);
    endfunction

    task automatic conv(input logic [15:0] v, input logic [15:0] exp_bin,
                        input logic exp_err, input string tag);
        int lat;
        int waitc;
        waitc = 0;
        @(negedge clk);
        while (!in_ready && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        chk({tag, "_ready"}, in_ready, 1'b1);
        in_valid = 1'b1;
        bcd_in   = v;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        bcd_in   = v ^ 16'h5A5A;
        chk({tag, "_busy"}, in_ready, 1'b0);
        lat = 1;
        while (!out_valid && lat < 40) begin
            if (lat == 4) begin
                in_valid = 1'b1;
                bcd_in   = 16'h0777;
            end
            if (lat == 6) in_valid = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;
        chk({tag, "_lat"}, lat, 32);
        chk({tag, "_bin"}, bin_out, exp_bin);
        chk({tag, "_err"}, out_error, exp_err);
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, out_valid, 1'b0);
        chk({tag, "_hold"}, bin_out, exp_bin);
        chk({tag, "_idle"}, in_ready, 1'b1);
    endtask

    initial begin
        logic [15:0] vecs [6];
        logic [15:0] accq [$];
        int          acct [$];
        int          got;
        int          seen;
        logic [15:0] r;

        // Reset state
        #2;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_bin", bin_out, 16'h0000);
        chk("rst_err", out_error, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", in_ready, 1'b1);

        // Directed conversions
        conv(16'h1234, 16'h04D2, 1'b0, "c1234");
        conv(16'h9999, 16'h270F, 1'b0, "c9999");
        conv(16'h0000, 16'h0000, 1'b0, "c0000");
        conv(16'h0001, 16'h0001, 1'b0, "c0001");
        conv(16'h12A4, 16'h0000, 1'b1, "c12A4");
        conv(16'h0042, 16'h002A, 1'b0, "c0042");

        // in_valid held with bcd_in changing every cycle
        vecs[0] = 16'h0137; vecs[1] = 16'h8642; vecs[2] = 16'h0999;
        vecs[3] = 16'h5005; vecs[4] = 16'h7310; vecs[5] = 16'h2468;
        got = 0;
        for (int cyc = 0; cyc < 300 && got < 4; cyc++) begin
            @(negedge clk);
            in_valid = 1'b1;
            bcd_in   = vecs[cyc % 6];
            if (in_ready) begin
                accq.push_back(bcd_in);
                acct.push_back(cyc);
            end
            @(posedge clk);
            #1;
            if (out_valid) begin
                r = accq.pop_front();
                chk("held_bin", bin_out, bcd2bin(r));
                got++;
            end
        end
        in_valid = 1'b0;
        chk("held_count", got, 4);
        chk("held_accepts", (acct.size() >= 4) ? 1'b1 : 1'b0, 1'b1);
        if (acct.size() >= 4) begin
            chk("held_gap1", acct[1] - acct[0], 33);
            chk("held_gap2", acct[2] - acct[1], 33);
            chk("held_gap3", acct[3] - acct[2], 33);
        end

        // Reset in the middle of a conversion
        seen = 0;
        @(negedge clk);
        while (!in_ready && seen < 100) begin
            @(negedge clk);
            seen++;
        end
        in_valid = 1'b1;
        bcd_in   = 16'h1234;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        chk("pre_rst_bin", bin_out, bcd2bin(vecs[3]));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_bin", bin_out, 16'h0000);
        chk("mid_rst_err", out_error, 1'b0);
        chk("mid_rst_valid", out_valid, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", in_ready, 1'b1);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("post_rst_no_pulse", seen, 0);
        conv(16'h0500, 16'h01F4, 1'b0, "c0500");

        // Random legal inputs
        for (int k = 0; k < 12; k++) begin
            r = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            conv(r, bcd2bin(r), 1'b0, "rand");
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
